// File: rtl/imem_loader.sv
// Byte-stream loader for the MIPS instruction memory: packs big-endian bytes into words,
// writes consecutive addresses, then releases the core. Opcode checker: IMEM_LOADER_OPCODE_CHECK_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_run,
  output logic              bad_opcode,
  output logic [7:0]        bad_count,
  output logic [ADDR_W-1:0] first_bad_addr
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  state_t            state_n;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   written;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_idx;
  logic [31:0]       word;
  logic [ADDR_W:0]   count_clamped;
  logic              start_ok;
  logic              last_word;

  // A request larger than the memory loads the whole memory once, never wrapping onto itself.
  assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
  assign start_ok      = start && (state == IDLE || state == DONE);
  assign last_word     = (written + 1'b1) == count_q;

  assign imem_addr  = addr;
  assign imem_wdata = word;

  // NOTE: every variable in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start_ok) state_n = (count_clamped == '0) ? DONE : RECV;
      RECV:       if (s_valid && byte_idx == 2'd3) state_n = WRITE;
      WRITE:      state_n = last_word ? DONE : RECV;
      default:    state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      imem_we  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cpu_run  <= 1'b0;
      count_q  <= '0;
      written  <= '0;
      addr     <= '0;
      byte_idx <= '0;
      word     <= '0;
    end else begin
      state   <= state_n;
      // Status outputs are registered copies of the next state, so they change with it.
      s_ready <= (state_n == RECV);
      imem_we <= (state_n == WRITE);
      busy    <= (state_n == RECV) || (state_n == WRITE);
      done    <= (state_n == DONE);
      cpu_run <= (state_n == DONE);

      if (start_ok) begin
        count_q  <= count_clamped;
        written  <= '0;
        addr     <= '0;
        byte_idx <= '0;
      end

      if (state == RECV && s_valid) begin
        word     <= {word[23:0], s_data};
        byte_idx <= byte_idx + 2'd1;
      end

      if (state == WRITE) begin
        addr    <= addr + 1'b1;
        written <= written + 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_OPCODE_CHECK_EN
  logic legal;

  always_comb begin
    legal = 1'b0;
    case (word[31:26])
      6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h02, 6'h03: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Flags describe the current load only; an unsupported word is still written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bad_opcode     <= 1'b0;
      bad_count      <= '0;
      first_bad_addr <= '0;
    end else if (start_ok) begin
      bad_opcode     <= 1'b0;
      bad_count      <= '0;
      first_bad_addr <= '0;
    end else if (state == WRITE && !legal) begin
      bad_opcode <= 1'b1;
      if (bad_count != 8'hFF) bad_count <= bad_count + 8'd1;
      if (!bad_opcode) first_bad_addr <= addr;
    end
  end
`else
  assign bad_opcode     = 1'b0;
  assign bad_count      = '0;
  assign first_bad_addr = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of loads plus hand-written corner sequences,
// with a write scoreboard fed as bytes are driven and drained on each imem_we.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              cpu_run;
  logic              bad_opcode;
  logic [7:0]        bad_count;
  logic [ADDR_W-1:0] first_bad_addr;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .cpu_run(cpu_run),
    .bad_opcode(bad_opcode), .bad_count(bad_count), .first_bad_addr(first_bad_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  typedef struct packed {
    int               count;
    logic [3:0][31:0] w;
    int               gap_word;
    int               gap_byte;
    int               gap_len;
    logic             exp_bad;
    logic [7:0]       exp_bad_count;
    logic [7:0]       exp_first;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   we_cyc[$];
  int   we_count  = 0;
  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  bit   busy_seen = 1'b0;
  vec_t vecs[4];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_seen = 1'b1;
    if (reset === 1'b0 && imem_we === 1'b1) begin
      we_count++;
      we_cyc.push_back(cyc);
      check("s_ready_low_in_write", s_ready, 0);
      if (sb_q.size() == 0) begin
        check("write_was_expected", sb_q.size(), 1);
      end else begin
        sb_e = sb_q.pop_front();
        check("wr_addr", imem_addr, sb_e.addr);
        check("wr_data", imem_wdata, sb_e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // All callers sit 1 ns after a rising edge.
  task automatic pulse_start(input logic [ADDR_W:0] n);
    start      = 1'b1;
    word_count = n;
    @(posedge clk); #1;
    start      = 1'b0;
    word_count = ADDR_W'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_at, input int gap_len,
                           output int first_cyc);
    first_cyc = -1;
    for (int b = 0; b < 4; b++) begin
      int t;
      if (b == gap_at && gap_len > 0) begin
        s_valid = 1'b0;
        repeat (gap_len) begin @(posedge clk); #1; end
      end
      s_valid = 1'b1;
      s_data  = w[31-8*b -: 8];
      t = 0;
      while (s_ready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) check("s_ready_timeout", t, 0);
      if (b == 0) first_cyc = cyc;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(output int dc);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    check("done_within_bound", t < 100, 1);
    dc = cyc;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {s_ready, imem_we, imem_addr, imem_wdata, busy, done, cpu_run,
                 bad_opcode, bad_count, first_bad_addr}, 0);
  endtask

  task automatic set_vec(input int i, input int cnt, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d, input int gw, input int gb,
                         input int gl, input logic eb, input logic [7:0] ec, input logic [7:0] ef);
    vecs[i].count    = cnt;
    vecs[i].w[0]     = a;
    vecs[i].w[1]     = b;
    vecs[i].w[2]     = c;
    vecs[i].w[3]     = d;
    vecs[i].gap_word = gw;
    vecs[i].gap_byte = gb;
    vecs[i].gap_len  = gl;
    vecs[i].exp_bad       = eb;
    vecs[i].exp_bad_count = ec;
    vecs[i].exp_first     = ef;
  endtask

  initial begin
    int base_we, first_c, n0, dc;

    set_vec(0, 3, 32'h8C010004, 32'h00221820, 32'h08000000, 32'h0, -1, 0, 0, 1'b0, 8'd0, 8'd0);
    set_vec(1, 3, 32'h8C010004, 32'h00221820, 32'h08000000, 32'h0,  1, 2, 3, 1'b0, 8'd0, 8'd0);
`ifdef IMEM_LOADER_OPCODE_CHECK_EN
    set_vec(2, 4, 32'h8C010004, 32'hFC000000, 32'h00221820, 32'h7C000000, -1, 0, 0, 1'b1, 8'd2, 8'd1);
`else
    set_vec(2, 4, 32'h8C010004, 32'hFC000000, 32'h00221820, 32'h7C000000, -1, 0, 0, 1'b0, 8'd0, 8'd0);
`endif
    set_vec(3, 1, 32'hAC220008, 32'h0, 32'h0, 32'h0, -1, 0, 0, 1'b0, 8'd0, 8'd0);

    reset = 1'b1; start = 1'b0; word_count = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("idle_outputs");

    // Zero-length load: straight to DONE, no write, never busy.
    busy_seen = 1'b0;
    base_we   = we_count;
    pulse_start(0);
    check("zero_done", {done, cpu_run, busy}, 3'b110);
    repeat (5) @(posedge clk);
    #1;
    check("zero_busy_seen", busy_seen, 0);
    check("zero_no_write", we_count - base_we, 0);
    check("zero_done_held", done, 1);

    for (int i = 0; i < 4; i++) begin
      base_we = we_count;
      n0 = 0;
      pulse_start(ADDR_W'(vecs[i].count));
      check("busy_after_start", busy, 1);
      check("done_dropped", {done, cpu_run}, 0);
      for (int k = 0; k < vecs[i].count; k++) begin
        sb_q.push_back('{addr: ADDR_W'(k), data: vecs[i].w[k]});
        send_word(vecs[i].w[k], (k == vecs[i].gap_word) ? vecs[i].gap_byte : -1,
                  vecs[i].gap_len, first_c);
        if (k == 0) n0 = first_c;
      end
      s_valid = 1'b0;
      wait_done(dc);
      check("write_count", we_count - base_we, vecs[i].count);
      if (vecs[i].gap_len == 0) begin
        for (int k = 0; k < vecs[i].count; k++)
          check("we_cycle", we_cyc[base_we+k], n0 + 5*k + 4);
      end else begin
        check("we_cycle_gap", we_cyc[we_count-1], n0 + 5*(vecs[i].count-1) + 4 + vecs[i].gap_len);
      end
      check("done_after_last_we", dc, we_cyc[we_count-1] + 1);
      check("done_state", {done, cpu_run, busy}, 3'b110);
      check("bad_opcode", bad_opcode, vecs[i].exp_bad);
      check("bad_count", bad_count, vecs[i].exp_bad_count);
      check("first_bad_addr", first_bad_addr, vecs[i].exp_first);
      check("sb_drained", sb_q.size(), 0);
    end

    // Oversized count clamps to a full memory image.
    base_we = we_count;
    pulse_start({(ADDR_W+1){1'b1}});
    for (int k = 0; k < (1 << ADDR_W); k++) begin
      logic [31:0] w;
`ifdef IMEM_LOADER_OPCODE_CHECK_EN
      w = {6'h3F, 26'($urandom)};
`else
      w = $urandom;
`endif
      sb_q.push_back('{addr: ADDR_W'(k), data: w});
      send_word(w, -1, 0, first_c);
    end
    s_valid = 1'b0;
    wait_done(dc);
    check("clamp_write_count", we_count - base_we, 1 << ADDR_W);
    check("clamp_sb_drained", sb_q.size(), 0);
`ifdef IMEM_LOADER_OPCODE_CHECK_EN
    check("clamp_bad", {bad_opcode, bad_count, first_bad_addr}, {1'b1, 8'hFF, 8'h00});
`else
    check("clamp_bad", {bad_opcode, bad_count, first_bad_addr}, 0);
`endif

    // A start pulse during a load must not restart it.
    base_we = we_count;
    pulse_start(2);
    sb_q.push_back('{addr: 8'd0, data: 32'h8C010004});
    sb_q.push_back('{addr: 8'd1, data: 32'h00221820});
    send_word(32'h8C010004, -1, 0, first_c);
    check("busy_during_write", busy, 1);
    pulse_start(5);
    send_word(32'h00221820, -1, 0, first_c);
    s_valid = 1'b0;
    wait_done(dc);
    check("ignored_start_writes", we_count - base_we, 2);
    check("ignored_start_sb", sb_q.size(), 0);

    // Reset after two bytes of the first word discards the partial word.
    pulse_start(2);
    s_valid = 1'b1; s_data = 8'hAA;
    @(posedge clk); #1;
    s_data = 8'hBB;
    @(posedge clk); #1;
    reset = 1'b1; s_valid = 1'b0;
    #1;
    check_all_zero("midload_reset_outputs");
    @(posedge clk); #1;
    reset = 1'b0;
    base_we = we_count;
    pulse_start(1);
    sb_q.push_back('{addr: 8'd0, data: 32'h10430002});
    send_word(32'h10430002, -1, 0, first_c);
    s_valid = 1'b0;
    wait_done(dc);
    check("fresh_load_writes", we_count - base_we, 1);
    check("fresh_load_sb", sb_q.size(), 0);
    check("fresh_load_done", {done, cpu_run, bad_opcode}, 3'b110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
